// File: rtl/logsoftmax_row_max_shift_if.sv
// Stream bundle for the row-max/shift stage of the LogSoftmax datapath.
//   master : upstream logit producer + downstream consumer side
//            (drives in_valid/in_data/out_ready)
//   slave  : the stage itself
//            (drives in_ready/out_valid/out_data/out_max/out_last/fsm_state)
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. valid never waits on ready. Once raised, valid and its payload
// hold until the transfer, and ready may be raised or dropped freely.
// fsm_state is a debug view of the stage FSM: 0 = FILL, 1 = DRAIN.
interface logsoftmax_row_max_shift_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_max;
  logic              out_last;
  logic              fsm_state;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_max, out_last, fsm_state
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_max, out_last, fsm_state
  );
endinterface

// File: rtl/logsoftmax_row_max_shift.sv
// Row maximum and shift stage ahead of the LogSoftmax exp/log-sum stage.
// The stage buffers ROW_LEN signed logits while tracking the row maximum
// (FILL). It then replays the row as sat(x_i - max), so every output is <= 0
// (DRAIN). FILL and DRAIN never overlap.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous reset, active-high
//   bus  : slave side of logsoftmax_row_max_shift_if
//          in_valid/in_ready/in_data     : logit input stream
//          out_valid/out_ready/out_data  : shifted output stream
//          out_max                       : row maximum, stable during DRAIN
//          out_last                      : marks element ROW_LEN-1 of a row
//          fsm_state                     : debug, 0 = FILL, 1 = DRAIN
module logsoftmax_row_max_shift #(
  parameter  int DATA_W  = 32,
  parameter  int ROW_LEN = 16,
  localparam int CNT_W   = $clog2(ROW_LEN)
) (
  input logic                          clk,
  input logic                          rst,
  logsoftmax_row_max_shift_if.slave    bus
);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_LEN - 1);

  state_t            state;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  rd_nxt;
  logic [DATA_W-1:0] max_q;
  logic [DATA_W-1:0] max_nxt;
  logic [DATA_W-1:0] out_data_q;
  logic              out_last_q;
  logic [DATA_W-1:0] buf_q [ROW_LEN];
  logic              in_fire;
  logic              out_fire;

  // x - m at DATA_W+1 bits. The only possible overflow is below the most
  // negative value, because m >= x for every buffered element.
  function automatic logic [DATA_W-1:0] sat_sub(
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] m
  );
    logic [DATA_W:0] d;
    d = {x[DATA_W-1], x} - {m[DATA_W-1], m};
    if (d[DATA_W] != d[DATA_W-1])
      sat_sub = {1'b1, {(DATA_W-1){1'b0}}};
    else
      sat_sub = d[DATA_W-1:0];
  endfunction

  // Ready and valid are pure decodes of the state register. Neither depends
  // on in_valid or out_ready.
  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = (state == DRAIN);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_max   = max_q;
  assign bus.fsm_state = state;

  assign in_fire  = bus.in_valid && (state == FILL);
  assign out_fire = bus.out_ready && (state == DRAIN);
  assign rd_nxt   = (rd_idx == LAST) ? '0 : rd_idx + CNT_W'(1);

  // Element 0 seeds the maximum. Later elements keep the signed larger value.
  always_comb begin
    max_nxt = max_q;
    if (wr_idx == '0 || $signed(bus.in_data) > $signed(max_q))
      max_nxt = bus.in_data;
  end

  // The row buffer holds data only, so it has no reset. Stale contents are
  // never read, because DRAIN is only entered after a full row is written.
  always_ff @(posedge clk) begin
    if (in_fire)
      buf_q[wr_idx] <= bus.in_data;
  end

  // out_data/out_last are registered one element ahead. On entry to DRAIN
  // they are loaded with element 0 against the final maximum, which includes
  // the beat being accepted now. On each accepted output they advance to the
  // next element, so they hold unchanged through any stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      wr_idx     <= '0;
      rd_idx     <= '0;
      max_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_fire) begin
            max_q <= max_nxt;
            if (wr_idx == LAST) begin
              wr_idx     <= '0;
              rd_idx     <= '0;
              state      <= DRAIN;
              out_data_q <= sat_sub(buf_q[0], max_nxt);
              out_last_q <= 1'b0;
            end else begin
              wr_idx <= wr_idx + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (rd_idx == LAST) begin
              rd_idx     <= '0;
              state      <= FILL;
              out_data_q <= '0;
              out_last_q <= 1'b0;
            end else begin
              rd_idx     <= rd_nxt;
              out_data_q <= sat_sub(buf_q[rd_nxt], max_q);
              out_last_q <= (rd_nxt == LAST);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_logsoftmax_row_max_shift.sv
module tb_logsoftmax_row_max_shift;

  localparam int DATA_W  = 32;
  localparam int ROW_LEN = 4;
  localparam int PK_W    = 2 * DATA_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logsoftmax_row_max_shift_if #(.DATA_W(DATA_W)) bus ();

  logsoftmax_row_max_shift #(
    .DATA_W (DATA_W),
    .ROW_LEN(ROW_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  // Packed beat: {out_last, out_max, out_data}
  logic [PK_W-1:0]   exp_q[$];
  logic [DATA_W-1:0] row [ROW_LEN];
  int                n_checks = 0;
  int                n_pass   = 0;
  bit                rand_ready = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [DATA_W-1:0] q16(input int v);
    return DATA_W'(v * 65536);
  endfunction

  // ---------------- monitor / scoreboard compare ----------------
  logic [PK_W-1:0] cur;
  logic [PK_W-1:0] held;
  logic [PK_W-1:0] exp_v;
  bit              stall_pending = 1'b0;

  always @(negedge clk) begin
    cur = {bus.out_last, bus.out_max, bus.out_data};
    if (bus.out_valid) begin
      check("drain_in_ready", bus.in_ready, 0);
      if (stall_pending) check("stall_hold", cur, held);
      if (bus.out_ready) begin
        stall_pending = 1'b0;
        n_checks++;
        assert (exp_q.size() != 0) n_pass++;
        else $error("FAIL unexpected_out: got %h expected no output", cur);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("out_beat", cur, exp_v);
        end
      end else begin
        stall_pending = 1'b1;
        held          = cur;
      end
    end else begin
      stall_pending = 1'b0;
      check("idle_zero", {bus.out_last, bus.out_data}, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic set_row(input logic [DATA_W-1:0] a, b, c, d);
    row[0] = a;
    row[1] = b;
    row[2] = c;
    row[3] = d;
  endtask

  // Call just after a rising edge. Holds the element until in_ready is seen.
  task automatic send_elem(input logic [DATA_W-1:0] d);
    bit taken = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int c = 0; c < 200 && !taken; c++) begin
      @(negedge clk);
      if (bus.in_ready) taken = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    assert (taken) n_pass++;
    else $error("FAIL in_accept_timeout: got no in_ready expected accept of %h", d);
  endtask

  // Reference model: signed maximum, then x - max clamped at the most negative value.
  task automatic send_row(input bit expect_out);
    longint mx;
    longint d;
    mx = longint'($signed(row[0]));
    for (int i = 1; i < ROW_LEN; i++)
      if (longint'($signed(row[i])) > mx) mx = longint'($signed(row[i]));
    if (expect_out) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        d = longint'($signed(row[i])) - mx;
        if (d < -64'sd2147483648) d = -64'sd2147483648;
        exp_q.push_back({(i == ROW_LEN - 1), mx[DATA_W-1:0], d[DATA_W-1:0]});
      end
    end
    for (int i = 0; i < ROW_LEN; i++) send_elem(row[i]);
    // One cycle after the last accept, element 0 must already be presented.
    if (expect_out) check("latency_valid", bus.out_valid, 1);
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    #1;
    n_checks++;
    assert (exp_q.size() == 0) n_pass++;
    else $error("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    fork
      ready_driver();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_max", bus.out_max, 0);
    check("rst_state", bus.fsm_state, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // basic row
    set_row(q16(1), q16(5), q16(3), q16(2));
    send_row(1);
    wait_drain();

    // all equal
    set_row(q16(7), q16(7), q16(7), q16(7));
    send_row(1);
    wait_drain();

    // saturation at the most negative value
    set_row(32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0);
    send_row(1);
    wait_drain();

    // negative row with tied maximum
    set_row(q16(-9), q16(-3), q16(-12), q16(-3));
    send_row(1);
    wait_drain();

    // random backpressure against the model
    rand_ready = 1'b1;
    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < ROW_LEN; i++) begin
        if (r % 3 == 0) row[i] = $urandom;
        else if (r % 3 == 1) row[i] = q16($urandom_range(0, 40) - 20);
        else row[i] = q16($urandom_range(0, 3));
      end
      send_row(1);
      wait_drain();
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 bus.out_ready = 1'b1;

    // reset after two inputs: partial row discarded
    send_elem(q16(100));
    send_elem(q16(200));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", bus.out_valid, 0);
    check("rst2_out_max", bus.out_max, 0);
    check("rst2_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // reset after one output: rest of row discarded
    set_row(q16(50), q16(60), q16(70), q16(80));
    send_row(1);
    c = 0;
    while (exp_q.size() != ROW_LEN - 1 && c < 100) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("one_out_before_rst", exp_q.size(), ROW_LEN - 1);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rst3_quiet", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    // fresh row after reset must use a fresh maximum
    set_row(q16(-20), q16(-10), q16(-30), q16(-15));
    send_row(1);
    wait_drain();

    repeat (4) @(posedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
